// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencing controller:
// state encoding, opcode field position, default multi-cycle range and RFlags bit map.
package exec_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        MC_WAIT = 3'd2,
        DONE    = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;

    localparam int MC_LO_DEF = 13;
    localparam int MC_HI_DEF = 17;

    localparam int FLAG_OVF     = 0;
    localparam int FLAG_ABOVE   = 1;
    localparam int FLAG_EQUAL   = 2;
    localparam int FLAG_BELOW   = 3;
    localparam int FLAG_BETWEEN = 4;
    localparam int FLAG_COLL    = 5;
    localparam int FLAG_ERR     = 6;

endpackage

// File: rtl/mc_down_counter.sv
// Loadable 4-bit down counter used to time the multi-cycle wait; stops at zero.
module mc_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    assign zero = (count == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 4'd1;
        end
    end

endmodule

// File: rtl/exec_stage_ctrl.sv
// Execute pipeline register sequencer: handshake intake, multi-cycle stretch,
// result presentation and error-driven flush.
module exec_stage_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int MC_LAT = 3,
    parameter int MC_LO  = MC_LO_DEF,
    parameter int MC_HI  = MC_HI_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_instr,
    output logic [DWIDTH-1:0] instr_q,
    output logic              exec_en,
    output logic              exec_flush,
    input  logic [6:0]        flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              op_busy,
    output logic [3:0]        mc_count,
    output logic              err_sticky,
    input  logic              err_clr
);

    localparam logic [4:0] OPC_MC_LO = 5'(MC_LO);
    localparam logic [4:0] OPC_MC_HI = 5'(MC_HI);
    localparam logic [3:0] WAIT_LOAD = 4'(MC_LAT - 1);

    state_t     state, state_nxt;
    logic       accept;
    logic       is_mc;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
    logic       err_set;
    logic [4:0] opcode;

    // Only the error bit steers sequencing; the remaining flags pass through the datapath.
    logic unused_flags;
    assign unused_flags = ^flags[FLAG_COLL:FLAG_OVF];

    assign opcode  = instr_q[OPC_HI:OPC_LO];
    assign is_mc   = (opcode >= OPC_MC_LO) && (opcode <= OPC_MC_HI) && (MC_LAT > 1);
    assign accept  = in_valid && in_ready;
    assign op_busy = (state != IDLE);

    mc_down_counter u_mc_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .count    (mc_count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        exec_en    = 1'b0;
        exec_flush = 1'b0;
        out_valid  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = EXEC;
            end
            EXEC: begin
                exec_en = 1'b1;
                if (is_mc) begin
                    cnt_load  = 1'b1;
                    state_nxt = MC_WAIT;
                end else begin
                    state_nxt = DONE;
                end
            end
            MC_WAIT: begin
                cnt_dec = !cnt_zero;
                if (mc_count == 4'd1) state_nxt = DONE;
            end
            DONE: begin
                // Registered flags are stable here, so the error check gates the result directly.
                if (flags[FLAG_ERR]) begin
                    err_set   = 1'b1;
                    state_nxt = FLUSH;
                end else begin
                    out_valid = 1'b1;
                    in_ready  = out_ready;
                    if (out_ready) state_nxt = in_valid ? EXEC : IDLE;
                end
            end
            FLUSH: begin
                exec_flush = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            instr_q    <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) instr_q <= in_instr;
            if (err_set) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_ctrl.sv
// Bench for exec_stage_ctrl: two builds (MC_LAT=3 and MC_LAT=1) share one stimulus stream
// and are compared every cycle against a timestamp-based transaction model.
module tb_exec_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [6:0]  flags;
    logic        out_ready;
    logic        err_clr;

    logic        in_ready_o   [2];
    logic [31:0] instr_q_o    [2];
    logic        exec_en_o    [2];
    logic        exec_flush_o [2];
    logic        out_valid_o  [2];
    logic        op_busy_o    [2];
    logic [3:0]  mc_count_o   [2];
    logic        err_sticky_o [2];

    exec_stage_ctrl #(.DWIDTH(32), .MC_LAT(3), .MC_LO(13), .MC_HI(17)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .in_instr(in_instr), .instr_q(instr_q_o[0]), .exec_en(exec_en_o[0]),
        .exec_flush(exec_flush_o[0]), .flags(flags), .out_valid(out_valid_o[0]),
        .out_ready(out_ready), .op_busy(op_busy_o[0]), .mc_count(mc_count_o[0]),
        .err_sticky(err_sticky_o[0]), .err_clr(err_clr)
    );

    exec_stage_ctrl #(.DWIDTH(32), .MC_LAT(1), .MC_LO(13), .MC_HI(17)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .in_instr(in_instr), .instr_q(instr_q_o[1]), .exec_en(exec_en_o[1]),
        .exec_flush(exec_flush_o[1]), .flags(flags), .out_valid(out_valid_o[1]),
        .out_ready(out_ready), .op_busy(op_busy_o[1]), .mc_count(mc_count_o[1]),
        .err_sticky(err_sticky_o[1]), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checking = 0;
    int cyc = 0;

    // Model: an op is described by the cycle it executes and the cycle its result becomes valid.
    int          lat       [2] = '{3, 1};
    bit          m_busy    [2];
    bit          m_flush   [2];
    bit          m_err     [2];
    int          m_exec_at [2];
    int          m_done_at [2];
    logic [31:0] m_iq      [2];

    function automatic bit m_in_done(input int i);
        return m_busy[i] && (cyc >= m_done_at[i]);
    endfunction

    function automatic bit m_ready(input int i);
        return (!m_busy[i] && !m_flush[i]) || (m_in_done(i) && out_ready && !flags[6]);
    endfunction

    task automatic chk(input int i, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (MC_LAT=%0d) cycle %0d: observed=%0h expected=%0h", tag, lat[i], cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk(i, "in_ready",   {31'd0, in_ready_o[i]},   {31'd0, m_ready(i)});
            chk(i, "out_valid",  {31'd0, out_valid_o[i]},  {31'd0, m_in_done(i) && !flags[6]});
            chk(i, "exec_en",    {31'd0, exec_en_o[i]},    {31'd0, m_busy[i] && (cyc == m_exec_at[i])});
            chk(i, "exec_flush", {31'd0, exec_flush_o[i]}, {31'd0, m_flush[i]});
            chk(i, "op_busy",    {31'd0, op_busy_o[i]},    {31'd0, m_busy[i] || m_flush[i]});
            chk(i, "mc_count",   {28'd0, mc_count_o[i]},
                (m_busy[i] && cyc > m_exec_at[i] && cyc < m_done_at[i]) ? 32'(m_done_at[i] - cyc) : 32'd0);
            chk(i, "err_sticky", {31'd0, err_sticky_o[i]}, {31'd0, m_err[i]});
            chk(i, "instr_q",    instr_q_o[i],             m_iq[i]);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit done, rdy, eset;
            int opc;
            if (!rst) begin
                m_busy[i]  = 0;
                m_flush[i] = 0;
                m_err[i]   = 0;
                m_iq[i]    = '0;
            end else begin
                done = m_in_done(i);
                rdy  = m_ready(i);
                eset = done && flags[6];
                if (in_valid && rdy) begin
                    opc          = int'(in_instr[31:27]);
                    m_iq[i]      = in_instr;
                    m_busy[i]    = 1;
                    m_exec_at[i] = cyc + 1;
                    m_done_at[i] = cyc + 1 + ((opc >= 13 && opc <= 17) ? lat[i] : 1);
                end else if (eset) begin
                    m_busy[i]  = 0;
                    m_flush[i] = 1;
                end else if (m_flush[i]) begin
                    m_flush[i] = 0;
                end else if (done && out_ready) begin
                    m_busy[i] = 0;
                end
                if (eset) m_err[i] = 1;
                else if (err_clr) m_err[i] = 0;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        #1;
        if (checking) check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic present(input logic [4:0] opc);
        logic [26:0] low;
        low      = 27'($urandom);
        in_valid = 1'b1;
        in_instr = {opc, low};
    endtask

    task automatic one_op(input logic [4:0] opc, input int wait_cycles);
        present(opc);
        tick();
        in_valid = 1'b0;
        repeat (wait_cycles) tick();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; flags = '0; out_ready = 1'b0; err_clr = 1'b0;
        tick();
        checking = 1;
        tick();
        rst = 1'b1;
        tick();

        // single-cycle, multi-cycle, and the opcodes just outside the multi-cycle range
        out_ready = 1'b1;
        one_op(5'd3, 4);
        one_op(5'd15, 6);
        one_op(5'd12, 4);
        one_op(5'd18, 4);
        one_op(5'd13, 6);
        one_op(5'd17, 6);
        one_op(5'd14, 6);

        // held result under back-pressure, then back-to-back acceptance
        out_ready = 1'b0;
        one_op(5'd5, 7);
        present(5'd2);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // error flush, then a set coinciding with clear
        out_ready = 1'b0;
        one_op(5'd4, 2);
        flags = 7'h40;
        tick();
        flags = 7'h15;
        repeat (3) tick();
        one_op(5'd6, 2);
        flags = 7'h7f;
        err_clr = 1'b1;
        tick();
        flags = 7'h00;
        err_clr = 1'b0;
        repeat (2) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        out_ready = 1'b1;
        tick();

        // reset while the long op is one cycle from completion
        one_op(5'd16, 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();

        for (int n = 0; n < 500; n++) begin
            logic [26:0] low;
            logic [4:0]  opc;
            low       = 27'($urandom);
            opc       = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(11, 19));
            rst       = ($urandom_range(0, 60) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_instr  = {opc, low};
            out_ready = $urandom_range(0, 9) < 7;
            flags     = {($urandom_range(0, 9) == 0), 6'($urandom)};
            err_clr   = $urandom_range(0, 9) == 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_stage_ctrl.md
Name: exec_stage_ctrl

Overview:
Sequencing controller for the processor's execute pipeline register.
- Accepts decoded instructions over a valid/ready handshake and pulses the execute register's load enable.
- Stretches multi-cycle compare/collision ops (opcode instr[31:27] in 13..17) over a programmable latency.
- Presents completed results downstream.
- Flushes the stage when the registered error flag (RFlags[6]) is raised.

Parameters:
DWIDTH, 32, instruction/data width
MC_LAT, 3, total execute cycles for multi-cycle ops (>=1, <=15)
MC_LO, 13, lowest multi-cycle opcode
MC_HI, 17, highest multi-cycle opcode

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (sampled at posedge clk; 0 = reset)
in_valid  in  1  upstream instruction valid
in_ready  out  1  controller can accept an instruction (combinational)
in_instr  in  DWIDTH  upstream instruction
instr_q  out  DWIDTH  captured instruction, drives execute register instr input
exec_en  out  1  execute register load enable
exec_flush  out  1  forces execute register to bubble (drives its reset path)
flags  in  7  RFlags from execute register (bit6 = error)
out_valid  out  1  result in execute register valid (combinational)
out_ready  in  1  downstream accepts result
op_busy  out  1  high in any state except IDLE
mc_count  out  4  remaining multi-cycle wait count
err_sticky  out  1  latched error indication
err_clr  in  1  clears err_sticky

Behaviour:
- Reset (rst=0 at edge):
  - state=IDLE; instr_q=0, mc_count=0, err_sticky=0.
  - exec_en, exec_flush, out_valid, op_busy all 0.
  - No flush pulse is generated by reset, including reset mid-operation; any in-flight op is dropped.
- States: IDLE, EXEC, MC_WAIT, DONE, FLUSH.
- Acceptance happens on in_valid & in_ready; instr_q captures in_instr at that edge.
- in_ready:
  - IDLE: 1.
  - DONE: out_ready & ~flags[6].
  - All other states: 0.
- IDLE: on acceptance -> EXEC.
- EXEC: exec_en=1 for exactly this cycle.
  - Opcode outside MC_LO..MC_HI, or MC_LAT=1 -> DONE.
  - Otherwise -> MC_WAIT with mc_count=MC_LAT-1.
- MC_WAIT:
  - exec_en=0; mc_count decrements by 1 each cycle.
  - When mc_count=1 at an edge -> DONE, and mc_count becomes 0.
- Latency, for acceptance at edge T:
  - exec_en is high in cycle T+1.
  - out_valid is first high in cycle T+2 (single-cycle op) or T+1+MC_LAT (multi-cycle op).
- DONE, evaluated every cycle from the stable registered flags:
  - flags[6]=1: out_valid=0, next state FLUSH.
  - Else out_valid=1, held until out_ready. On out_valid & out_ready:
    - in_valid=1 -> accept and go to EXEC (back-to-back; throughput 1 single-cycle op per 2 cycles).
    - in_valid=0 -> IDLE.
- FLUSH: exec_flush=1 for exactly one cycle, then IDLE.
  - err_sticky set at the edge entering FLUSH.
- err_sticky: err_clr=1 clears it; a simultaneous set wins over clear.
- instr_q holds its value outside acceptance edges.
- mc_count is 0 outside MC_WAIT.
- in_valid while busy is ignored; upstream must hold it.
- in_instr need not be stable after acceptance.

Decomposition:
- Package exec_ctrl_pkg:
  - state encoding constants.
  - opcode field bounds (OPC_HI=31, OPC_LO=27).
  - default MC_LO/MC_HI.
  - RFlags bit indices (OVF=0, ABOVE=1, EQUAL=2, BELOW=3, BETWEEN=4, COLL=5, ERR=6).
- One sub-module, mc_down_counter: loadable 4-bit down counter with load, dec and zero outputs, used for the MC_WAIT countdown.

Test Plan:
- Reset then single-cycle op: rst low 2 cycles, then in_instr opcode 3 accepted at T -> exec_en high at T+1 only; out_valid at T+2; out_ready=1 -> IDLE; op_busy low at T+3.
- Multi-cycle op, MC_LAT=3: opcode 15 accepted at T -> exec_en at T+1; mc_count 2,1 in T+2,T+3; out_valid at T+4. Repeat with opcodes 12 and 18 -> treated as single-cycle.
- Back-pressure and back-to-back: out_ready=0 for 5 cycles in DONE -> out_valid held, in_ready=0. Then out_ready=1 with in_valid=1 (opcode 2) -> accepted same edge; exec_en next cycle.
- Error flush: flags[6]=1 while in DONE -> out_valid=0; FLUSH next cycle with exec_flush one-cycle pulse; err_sticky=1; IDLE after. err_clr=1 together with a new set -> err_sticky stays 1.
- Reset mid-op: rst=0 during MC_WAIT (mc_count=1) -> next cycle IDLE, mc_count=0, exec_flush never pulses, out_valid never asserts.
- MC_LAT=1 build: opcode 14 accepted at T -> out_valid at T+2; MC_WAIT never entered.
